led_scan_sequencer: RTL and testbench
=====================================

Name: led_scan_sequencer

Overview:
- Round-robin scheduler that shares the single 3-to-8 active-low LED decoder among 8 requesting channels.
- Each requester raises a bit of req. The block grants one channel at a time and drives the decoder's switch/enable inputs.
- Each grant is held for DWELL cycles, then the block moves to the next pending requester.
- Sits directly upstream of the LED decoder. The decoder lights channel switch only when enable==3'd4; enable==3'd0 blanks all LEDs.

Parameters:
- DWELL, 4, cycles each grant is held (legal range 1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  8  per-channel request, level-sensitive
- pause  in  1  freezes dwell countdown and blocks new grants while high
- switch  out  3  decoder channel select (index of granted channel)
- enable  out  3  decoder enable: 3'd4 while a grant is active, 3'd0 otherwise
- grant  out  8  one-hot granted channel, 0 when idle
- busy  out  1  high while a grant is active
- slot_done  out  1  one-cycle pulse on the cycle a slot completes

Behaviour:
- Reset:
  - rst==0 at a rising edge forces switch=0, enable=0, grant=0, busy=0, slot_done=0.
  - Internal RR pointer ptr=0, dwell counter=0, state=IDLE.
  - Reset has priority over every other input.
- All outputs are registered.
- States: IDLE, HOLD.
- RR pick:
  - Scan req from index ptr upward, mod 8; select the first set bit.
  - ptr advances to (granted index + 1) mod 8 only when a slot completes.
- IDLE:
  - If pause==0 and req!=0: pick idx, then at that edge set switch=idx, enable=4, grant=1<<idx, busy=1, counter=DWELL-1, go to HOLD. Latency is 1 cycle from req high to grant.
  - Otherwise stay in IDLE; outputs unchanged (enable=0, grant=0, busy=0).
- HOLD:
  - pause==1: counter and all outputs frozen, no transition.
  - pause==0 and counter!=0: counter decrements; outputs held.
  - pause==0 and counter==0 (slot ends):
    - slot_done=1 for exactly that next cycle.
    - ptr=(idx+1) mod 8.
    - Re-run the RR pick from the new ptr against the current req. The current channel is eligible if it is still requesting.
    - If a channel is found: load the new grant at the same edge, with no idle gap; counter=DWELL-1; stay in HOLD.
    - Else: go to IDLE with enable=0, grant=0, busy=0. switch keeps its last value.
- Non-preemptive: dropping req for the granted channel mid-slot does not shorten the slot.
- DWELL==1: every non-paused HOLD cycle completes a slot. A single requester holds its grant continuously, with slot_done high every cycle.
- slot_done is 0 in all cycles except the one following a completion edge.
- Invariants:
  - grant is one-hot or zero.
  - busy==(grant!=0)==(enable==3'd4).
  - When busy, switch==index of grant.

Test Plan:
- Hold rst=0 for 2 cycles, then release with req=0 -> switch=0, enable=0, grant=0, busy=0, slot_done=0 throughout.
- DWELL=4, req=8'h04 held -> 1 cycle later switch=2, enable=4, grant=8'h04, busy=1. slot_done pulses every 4 cycles; grant stays 8'h04 with no idle cycle.
- DWELL=4, req=8'h81 held from reset -> grant sequence 8'h01, 8'h80, 8'h01, 8'h80, each for 4 cycles. switch alternates 0/7.
- DWELL=4, req=8'h10 pulsed for 1 cycle -> grant=8'h10, switch=4 for 4 cycles, one slot_done pulse, then IDLE: enable=0, grant=0, busy=0, switch stays 4.
- DWELL=4, pause=1 for 3 cycles starting in the 2nd cycle of a slot -> grant held 7 cycles total; slot_done delayed by 3. A pause asserted in IDLE with req=8'h01 -> no grant until pause drops, then grant=8'h01 the next cycle.
- Assert rst=0 for one edge mid-slot with req=8'hFF -> next cycle all outputs 0. After release, first grant is 8'h01 (ptr reset to 0), then 8'h02, 8'h04, and so on.

Source files
------------

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer
//   Round-robin scheduler that time-shares a single 3-to-8 active-low LED
//   decoder among 8 requesting channels. One channel is granted at a time and
//   held for DWELL cycles. When the slot ends, the next pending requester is
//   granted on the same edge, so there is no idle gap between slots.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active low
//   req[7:0]   per-channel request, level-sensitive
//   pause      freezes the dwell countdown and blocks new grants while high
//   switch[2:0]  decoder channel select (index of the granted channel)
//   enable[2:0]  decoder enable: 3'd4 while a grant is active, 3'd0 otherwise
//   grant[7:0] one-hot granted channel, zero when idle
//   busy       high while a grant is active
//   slot_done  one-cycle pulse on the cycle after a slot completes
//
// All outputs are registered.

module led_scan_sequencer #(
    parameter int DWELL = 4  // cycles each grant is held, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       pause,
    output logic [2:0] switch,
    output logic [2:0] enable,
    output logic [7:0] grant,
    output logic       busy,
    output logic       slot_done
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);
    localparam logic [2:0] EN_ON      = 3'd4;
    localparam logic [2:0] EN_OFF     = 3'd0;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] idx_n;
    logic       done_n;

    logic [2:0] switch_n;
    logic [2:0] enable_n;
    logic [7:0] grant_n;
    logic       busy_n;

    // Round-robin pick: first set bit of r scanning upward from base, mod 8.
    // Returns {found, index}. The loop runs from the farthest offset down so
    // the nearest requester is the last (winning) assignment.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] pos;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            pos = base + 3'(i);
            if (r[pos]) res = {1'b1, pos};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the comb blocks below use blocking ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= 8'd0;
            switch    <= 3'd0;
            enable    <= EN_OFF;
            grant     <= 8'd0;
            busy      <= 1'b0;
            slot_done <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            switch    <= switch_n;
            enable    <= enable_n;
            grant     <= grant_n;
            busy      <= busy_n;
            slot_done <= done_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        logic [3:0] pick;
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        idx_n   = switch;   // switch keeps its last value when idle
        done_n  = 1'b0;
        pick    = 4'b0;

        unique case (state)
            IDLE: begin
                if (!pause && req != 8'd0) begin
                    pick    = rr_pick(req, ptr);
                    idx_n   = pick[2:0];
                    cnt_n   = DWELL_LOAD;
                    state_n = HOLD;
                end
            end

            HOLD: begin
                if (!pause) begin
                    if (cnt != 8'd0) begin
                        cnt_n = cnt - 8'd1;
                    end else begin
                        // Slot ends: advance past the current channel and
                        // re-arbitrate at the same edge. The current channel
                        // is still eligible (it is the last one scanned).
                        done_n = 1'b1;
                        ptr_n  = switch + 3'd1;
                        pick   = rr_pick(req, switch + 3'd1);
                        if (pick[3]) begin
                            idx_n = pick[2:0];
                            cnt_n = DWELL_LOAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (next values, registered above)
    // ------------------------------------------------------------------
    always_comb begin
        switch_n = idx_n;
        enable_n = EN_OFF;
        grant_n  = 8'd0;
        busy_n   = 1'b0;
        if (state_n == HOLD) begin
            enable_n = EN_ON;
            grant_n  = 8'd1 << idx_n;
            busy_n   = 1'b1;
        end
    end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed testbench for led_scan_sequencer. A DWELL=4 instance carries the
// main checks; a DWELL=1 instance shares the same inputs and is checked in
// the single-requester scenario.

module tb_led_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       pause;

    logic [2:0] switch,  switch1;
    logic [2:0] enable,  enable1;
    logic [7:0] grant,   grant1;
    logic       busy,    busy1;
    logic       slot_done, slot_done1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_scan_sequencer #(.DWELL(4)) dut (
        .clk(clk), .rst(rst), .req(req), .pause(pause),
        .switch(switch), .enable(enable), .grant(grant),
        .busy(busy), .slot_done(slot_done)
    );

    led_scan_sequencer #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .pause(pause),
        .switch(switch1), .enable(enable1), .grant(grant1),
        .busy(busy1), .slot_done(slot_done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full output check of the DWELL=4 instance.
    task automatic check_out(input string tag, input logic [2:0] sw, input logic [7:0] g,
                             input logic sd);
        logic on;
        on = (g != 8'd0);
        check({tag, ".switch"},    32'(switch),    32'(sw));
        check({tag, ".enable"},    32'(enable),    on ? 32'd4 : 32'd0);
        check({tag, ".grant"},     32'(grant),     32'(g));
        check({tag, ".busy"},      32'(busy),      32'(on));
        check({tag, ".slot_done"}, 32'(slot_done), 32'(sd));
    endtask

    task automatic do_reset();
        rst = 1'b0; req = 8'd0; pause = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req = 8'd0; pause = 1'b0;

        // ---------------- Reset, idle with no requests ----------------
        step();
        check_out("rst0", 3'd0, 8'h00, 1'b0);
        step();
        check_out("rst1", 3'd0, 8'h00, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("idle", 3'd0, 8'h00, 1'b0);
        end

        // ---------------- Single requester, held ----------------
        do_reset();
        req = 8'h04;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_out("single", 3'd2, 8'h04, (k >= 5) && ((k - 1) % 4 == 0));
            // DWELL=1: grant held continuously, slot_done every cycle after the first
            check("d1.grant",     32'(grant1),     32'h04);
            check("d1.switch",    32'(switch1),    32'd2);
            check("d1.slot_done", 32'(slot_done1), 32'(k >= 2));
        end

        // ---------------- Two requesters alternate ----------------
        rst = 1'b0; req = 8'h81; pause = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (((k - 1) / 4) % 2 == 0)
                check_out("alt", 3'd0, 8'h01, (k >= 5) && ((k - 1) % 4 == 0));
            else
                check_out("alt", 3'd7, 8'h80, (k - 1) % 4 == 0);
        end

        // ---------------- One-cycle request pulse ----------------
        do_reset();
        req = 8'h10;
        step();
        req = 8'h00;
        check_out("pulse1", 3'd4, 8'h10, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            step();
            check_out("pulse_hold", 3'd4, 8'h10, 1'b0);
        end
        step();
        check_out("pulse_end", 3'd4, 8'h00, 1'b1);
        step();
        check_out("pulse_idle", 3'd4, 8'h00, 1'b0);

        // ---------------- Pause mid-slot ----------------
        do_reset();
        req = 8'h01;
        step();                       // E1: grant, first cycle of slot
        req = 8'h00;
        pause = 1'b1;
        check_out("pause_e1", 3'd0, 8'h01, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            step();
            check_out("pause_frz", 3'd0, 8'h01, 1'b0);
        end
        pause = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            step();
            check_out("pause_run", 3'd0, 8'h01, 1'b0);
        end
        step();                       // E8: slot completes, 3 cycles late
        check_out("pause_end", 3'd0, 8'h00, 1'b1);

        // ---------------- Pause in IDLE blocks a grant ----------------
        pause = 1'b1;
        req = 8'h01;
        step();
        check_out("idle_pause0", 3'd0, 8'h00, 1'b0);
        step();
        check_out("idle_pause1", 3'd0, 8'h00, 1'b0);
        pause = 1'b0;
        step();
        check_out("idle_unpause", 3'd0, 8'h01, 1'b0);

        // ---------------- Reset mid-slot, all channels requesting ----------------
        do_reset();
        req = 8'hFF;
        step();
        check_out("ff_first", 3'd0, 8'h01, 1'b0);
        step();
        rst = 1'b0;
        step();
        check_out("midrst", 3'd0, 8'h00, 1'b0);
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check_out("ff_rr", 3'((k - 1) / 4), 8'(8'd1 << ((k - 1) / 4)),
                      (k >= 5) && ((k - 1) % 4 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
